// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: time-multiplexed AES SubBytes over LANES S-box lanes; inverse tables enabled by SUB_BYTES_INV_EN
module sub_bytes_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam int BEATS = 16 / LANES;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [2047:0] FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
`ifdef SUB_BYTES_INV_EN
  localparam logic [2047:0] INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
`endif
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CW-1:0] beat;
  logic [127:0] work;
  logic [6:0] off;
  logic [8*LANES-1:0] lane_in, lane_out;
  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end
  function automatic logic [7:0] lookup(input logic [2047:0] t, input logic [7:0] x);
    return t[11'd2047 - {x, 3'b000} -: 8];
  endfunction
  assign off = 7'(beat) * 7'(8 * LANES);
  assign lane_in = work[7'd127 - off -: 8*LANES];
  assign out_data = work;
`ifdef SUB_BYTES_INV_EN
  logic inv;
  // mode flag captured once per block at acceptance
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) inv <= 1'b0;
    else if (state == IDLE && in_valid) inv <= in_inv;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_out[8*l +: 8] = inv ? lookup(INV, lane_in[8*l +: 8]) : lookup(FWD, lane_in[8*l +: 8]);
  end
`else
  logic in_inv_unused;
  assign in_inv_unused = in_inv;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_out[8*l +: 8] = lookup(FWD, lane_in[8*l +: 8]);
  end
`endif
  // control FSM: accept, substitute one lane group per beat, hold result until handed off
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= '0;
      work      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work     <= in_data;
          beat     <= '0;
          state    <= RUN;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        RUN: begin
          work[7'd127 - off -: 8*LANES] <= lane_out;
          beat <= beat + 1'b1;
          if (beat == CW'(BEATS - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sub_bytes_engine.sv
// tb_sub_bytes_engine: directed checks of sub_bytes_engine across LANES = 4, 1, 16, 2, 8
module tb_sub_bytes_engine;
  localparam int NI = 5;
  localparam int LN [NI] = '{4, 1, 16, 2, 8};
  localparam logic [127:0] PT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] ST = 128'hd42711aee0bf98f1b8b45de51e415230;
  logic clk = 1'b0;
  logic rst_n;
  logic in_valid [NI], in_ready [NI], in_inv [NI], out_valid [NI], out_ready [NI], busy [NI];
  logic [127:0] in_data [NI], out_data [NI];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sub_bytes_engine #(.LANES(LN[g])) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_data(in_data[g]), .in_inv(in_inv[g]), .out_valid(out_valid[g]),
      .out_ready(out_ready[g]), .out_data(out_data[g]), .busy(busy[g]));
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] b = 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) b = 8'(y);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_model(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_model(d[8*i +: 8]);
    return r;
  endfunction

  task automatic run_block(input int k, input logic [127:0] d, input logic inv,
                           output logic [127:0] res, output int lat);
    in_data[k] = d;
    in_inv[k] = inv;
    in_valid[k] = 1'b1;
    @(negedge clk);
    in_valid[k] = 1'b0;
    in_inv[k] = ~inv;
    in_data[k] = ~d;
    lat = 0;
    while (!out_valid[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = out_data[k];
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if ({in_ready[k], out_valid[k], busy[k], out_data[k]} !== {3'b100, 128'h0}) begin
        n_bad++;
        $display("FAIL reset[%0d]: got rdy/vld/busy=%b%b%b data=%h, want 100 data=0", k,
                 in_ready[k], out_valid[k], busy[k], out_data[k]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release: in_ready=%b, want 1", in_ready[0]);
    end
  endtask

  task automatic test_forward;
    logic [127:0] r;
    int lat;
    run_block(0, PT, 1'b0, r, lat);
    n_cmp++;
    if (r !== ST) begin
      n_bad++;
      $display("FAIL fwd_data: got %h want %h", r, ST);
    end
    n_cmp++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL fwd_latency: got %0d want 4", lat);
    end
  endtask

  task automatic test_inverse;
    logic [127:0] r, exp;
    int lat;
`ifdef SUB_BYTES_INV_EN
    exp = PT;
`else
    exp = sub_model(ST);
`endif
    run_block(1, ST, 1'b1, r, lat);
    n_cmp++;
    if (r !== exp) begin
      n_bad++;
      $display("FAIL inv_data: got %h want %h", r, exp);
    end
    n_cmp++;
    if (lat !== 16) begin
      n_bad++;
      $display("FAIL inv_latency: got %0d want 16", lat);
    end
  endtask

  task automatic test_table;
    logic [127:0] d, r, exp;
    int lat;
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 16; i++) d[127 - 8*i -: 8] = 8'(16*j + i);
      exp = sub_model(d);
      run_block(2, d, 1'b0, r, lat);
      n_cmp++;
      if (r !== exp || lat !== 1) begin
        n_bad++;
        $display("FAIL table_fwd[%0d]: got %h lat %0d want %h lat 1", j, r, lat, exp);
      end
      if (j == 0) begin
        n_cmp++;
        if (r[127:120] !== 8'h63) begin
          n_bad++;
          $display("FAIL sbox_00: got %h want 63", r[127:120]);
        end
      end
      if (j == 5) begin
        n_cmp++;
        if (r[103:96] !== 8'hed) begin
          n_bad++;
          $display("FAIL sbox_53: got %h want ed", r[103:96]);
        end
      end
      if (j == 15) begin
        n_cmp++;
        if (r[7:0] !== 8'h16) begin
          n_bad++;
          $display("FAIL sbox_ff: got %h want 16", r[7:0]);
        end
      end
`ifdef SUB_BYTES_INV_EN
      begin
        logic [127:0] ri;
        run_block(2, exp, 1'b1, ri, lat);
        n_cmp++;
        if (ri !== d || lat !== 1) begin
          n_bad++;
          $display("FAIL table_inv[%0d]: got %h lat %0d want %h lat 1", j, ri, lat, d);
        end
      end
`endif
    end
  endtask

  task automatic test_backpressure;
    int lat = 0;
    in_data[0] = PT;
    in_inv[0] = 1'b0;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    while (!out_valid[0] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    in_data[0] = 128'h0;
    in_valid[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid[0], in_ready[0], busy[0], out_data[0]} !== {3'b101, ST}) begin
        n_bad++;
        $display("FAIL backpressure[%0d]: vld/rdy/busy=%b%b%b data=%h, want 101 data=%h", c,
                 out_valid[0], in_ready[0], busy[0], out_data[0], ST);
      end
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    n_cmp++;
    if ({out_valid[0], in_ready[0], busy[0], out_data[0]} !== {3'b010, ST}) begin
      n_bad++;
      $display("FAIL handoff: vld/rdy/busy=%b%b%b data=%h, want 010 data=%h",
               out_valid[0], in_ready[0], busy[0], out_data[0], ST);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [127:0] r;
    int lat;
    in_data[3] = PT;
    in_inv[3] = 1'b0;
    in_valid[3] = 1'b1;
    @(negedge clk);
    in_valid[3] = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy[3] !== 1'b1) begin
      n_bad++;
      $display("FAIL midrun_busy: got %b want 1", busy[3]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid[3], busy[3], in_ready[3], out_data[3]} !== {3'b001, 128'h0}) begin
      n_bad++;
      $display("FAIL midrun_reset: vld/busy/rdy=%b%b%b data=%h, want 001 data=0",
               out_valid[3], busy[3], in_ready[3], out_data[3]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_block(3, PT, 1'b0, r, lat);
    n_cmp++;
    if (r !== ST || lat !== 8) begin
      n_bad++;
      $display("FAIL after_reset: got %h lat %0d want %h lat 8", r, lat, ST);
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] blk [4];
    logic [127:0] got [$];
    int oc [$];
    int sent = 0;
    blk[0] = PT;
    blk[1] = 128'h0;
    blk[2] = '1;
    blk[3] = 128'h00112233445566778899aabbccddeeff;
    out_ready[4] = 1'b1;
    in_valid[4] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (out_valid[4]) begin
        got.push_back(out_data[4]);
        oc.push_back(c);
      end
      if (in_ready[4] && sent < 4) begin
        in_data[4] = blk[sent];
        in_inv[4] = 1'b0;
        sent++;
      end else begin
        in_inv[4] = ~in_inv[4];
        if (in_ready[4]) in_valid[4] = 1'b0;
      end
      @(negedge clk);
    end
    in_valid[4] = 1'b0;
    out_ready[4] = 1'b0;
    n_cmp++;
    if (got.size() !== 4) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d results want 4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== sub_model(blk[i])) begin
        n_bad++;
        $display("FAIL b2b_data[%0d]: got %h want %h", i, got[i], sub_model(blk[i]));
      end
      if (i > 0) begin
        n_cmp++;
        if (oc[i] - oc[i-1] !== 4) begin
          n_bad++;
          $display("FAIL b2b_spacing[%0d]: got %0d cycles want 4", i, oc[i] - oc[i-1]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      in_valid[k] = 1'b0;
      in_inv[k] = 1'b0;
      out_ready[k] = 1'b0;
      in_data[k] = '0;
    end
    test_reset;
    test_forward;
    test_inverse;
    test_table;
    test_backpressure;
    test_reset_mid_run;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
